rf_scoreboard: RTL and testbench
================================

# rf_scoreboard

Parametrised successor to the CPU register file: a 2-read / 1-write register file with configurable width and depth, byte-granular write enables, optional same-cycle write-to-read bypass and an integrated per-register busy scoreboard. It sits in the decode/writeback stages of the CPU core. Decode reads operands and marks the destination register busy on issue. Writeback writes results and clears busy. A stall output flags read-after-write hazards to the pipeline control.

## Interface
Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8
- ADDR_W, 5, address width; depth = 2**ADDR_W
- ZERO_REG, 1, 1: register 0 reads as 0, ignores writes and is never busy
- BYPASS, 1, 1: a write in the current cycle is forwarded to matching read ports combinationally
- INIT_MODE, 0, 0: register i resets to i truncated to DATA_W; 1: all registers reset to 0

Ports (one clock; reset is asynchronous and active-high):
- Clk_CPU  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- A1, A2  in  ADDR_W  read addresses
- use1, use2  in  1  read port actually needed by the current instruction
- RD1, RD2  out  DATA_W  read data (combinational)
- RFWr  in  1  write enable
- A3  in  ADDR_W  write address
- WD  in  DATA_W  write data
- WBE  in  DATA_W/8  byte write enables; bit k covers WD[8k+7:8k]
- iss_valid  in  1  issue: mark iss_rd busy
- iss_rd  in  ADDR_W  destination register of the issuing instruction
- flush  in  1  clear all busy bits
- busy1, busy2  out  1  operand at A1/A2 still pending
- stall  out  1  (use1 & busy1) | (use2 & busy2)

## Operation
- Storage: 2**ADDR_W × DATA_W registers, plus 2**ADDR_W busy bits.
- Write: at the rising edge with RFWr=1, each byte k of rf[A3] whose WBE[k]=1 takes WD byte k; the other bytes hold.
  - RFWr=1 with WBE=0 changes nothing, but still counts as a writeback for the scoreboard.
- Read, effective data per port n:
  - If ZERO_REG=1 and An=0: 0.
  - Else if BYPASS=1, RFWr=1 and A3=An: the byte-merge of WD (enabled bytes) with rf[An] (other bytes).
  - Else: rf[An].
- Busy update at each rising edge, with this priority:
  - flush=1: all busy bits clear; iss_valid is ignored that cycle.
  - Else, for each register r:
    - set if iss_valid=1 and iss_rd=r;
    - else clear if RFWr=1 and A3=r;
    - else hold.
  - Issue and writeback to the same register in one cycle leaves it busy: the write completes the old producer, and the new producer is outstanding.
- busyN output:
  - 0 if ZERO_REG=1 and An=0.
  - 0 if BYPASS=1, RFWr=1 and A3=An (the result is being forwarded).
  - Otherwise busy[An].
- ZERO_REG=1: writes and issues to register 0 are ignored.
- There is no FSM. State is the register array and the busy vector; all outputs are combinational from state and inputs.

## Timing
- Read latency: 0 cycles (combinational).
- Write latency: visible on reads from the next cycle. With BYPASS=1 it is also visible in the same cycle.
- Busy set by issue in cycle t: busyN=1 from cycle t+1 until the cycle of the matching writeback.
  - With BYPASS=1, busyN=0 during that writeback cycle itself.
  - With BYPASS=0, busyN=0 from the cycle after it.
- flush in cycle t: all busy=0 from t+1.
- Reset (asynchronous, effective immediately, any time including mid-operation):
  - rf[i] = INIT_MODE ? 0 : i; all busy=0.
  - Outputs after reset: RD1=A1, RD2=A2 (INIT_MODE=0, A≠0) else 0; busy1=busy2=stall=0.
  - Register writes, issues and flush are ignored while rst=1.
- Index wrap: (INIT_MODE=0) reset value i is truncated when DATA_W < ADDR_W.

## Test plan
- Reset with defaults, then read A1=5, A2=31 → RD1=5, RD2=31, stall=0; read A1=0 → RD1=0. Assert rst mid-run after writes → all values revert immediately.
- Byte writes: reg 7 resets to 7.
  - RFWr=1, A3=7, WD=0xAABBCCDD, WBE=4'b0101 → next cycle rf[7]=0x00BB00DD.
  - Same cycle with BYPASS=1, A1=7 → RD1=0x00BB00DD.
  - Same with BYPASS=0 → RD1=7.
- Zero register: write 0xFFFFFFFF to A3=0 and issue iss_rd=0 → RD1(A1=0)=0, busy1=0.
- Scoreboard:
  - iss_valid, iss_rd=3 at t → t+1 with A1=3, use1=1: busy1=1, stall=1.
  - With use1=0 → stall=0.
  - Writeback A3=3 at t+4 → busy1=0 and RD1=WD in t+4 (BYPASS=1).
- Simultaneous events:
  - Issue iss_rd=9 and writeback A3=9 in the same cycle → reg 9 stays busy next cycle and rf[9]=WD.
  - flush with iss_valid (iss_rd=4) → next cycle all busy=0, including reg 4.
- Parameter sweep: DATA_W=16, ADDR_W=3, INIT_MODE=1 → 8 registers reset to 0; a write to A3=7 with WBE=2'b10 updates only bits 15:8.

Source files
------------

// File: rtl/rf_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
//
// 2-read / 1-write register file with byte-granular write enables, optional
// same-cycle write-to-read bypass and a per-register busy scoreboard. Decode
// reads operands and marks its destination busy at issue. Writeback writes the
// result and clears busy. stall reports a read-after-write hazard on any
// operand the current instruction actually uses.
//
// Handshake: there is no valid/ready pairing here. Every input qualifier
// (RFWr, iss_valid, flush) is a single-cycle strobe sampled at the rising edge
// of Clk_CPU. All outputs are combinational from state and current inputs.
//
// Ports:
//   Clk_CPU        clock, rising edge
//   rst            asynchronous active-high reset
//   A1, A2         read addresses
//   use1, use2     read port is needed by the current instruction
//   RD1, RD2       read data (combinational)
//   RFWr           write enable
//   A3             write address
//   WD             write data
//   WBE            byte write enables, bit k covers WD[8k+7:8k]
//   iss_valid      issue strobe: mark iss_rd busy
//   iss_rd         destination register of the issuing instruction
//   flush          clear all busy bits
//   busy1, busy2   operand at A1/A2 still pending
//   stall          (use1 & busy1) | (use2 & busy2)
// -----------------------------------------------------------------------------
module rf_scoreboard #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1,
    parameter int INIT_MODE = 0
) (
    input  logic                  Clk_CPU,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     A1,
    input  logic [ADDR_W-1:0]     A2,
    input  logic                  use1,
    input  logic                  use2,
    output logic [DATA_W-1:0]     RD1,
    output logic [DATA_W-1:0]     RD2,
    input  logic                  RFWr,
    input  logic [ADDR_W-1:0]     A3,
    input  logic [DATA_W-1:0]     WD,
    input  logic [DATA_W/8-1:0]   WBE,
    input  logic                  iss_valid,
    input  logic [ADDR_W-1:0]     iss_rd,
    input  logic                  flush,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  stall
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0] rf [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;

    // Byte-merge of new data into an existing word under the byte enables.
    function automatic logic [DATA_W-1:0] merge(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [NB-1:0]     be
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int k = 0; k < NB; k++) begin
            if (be[k]) res[8*k +: 8] = new_word[8*k +: 8];
        end
        return res;
    endfunction

    // Register 0 is hardwired when ZERO_REG is set: writes and issues to it
    // have no effect on either storage or the scoreboard.
    logic wr_ok;
    logic iss_ok;
    logic wr_live;

    assign wr_ok   = RFWr && !(ZERO_REG != 0 && A3 == '0);
    assign iss_ok  = iss_valid && !(ZERO_REG != 0 && iss_rd == '0);
    // A write held during reset is not forwarded, so reset outputs are clean.
    assign wr_live = RFWr && !rst;

    // Register array.
    always_ff @(posedge Clk_CPU or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf[i] <= (INIT_MODE != 0) ? '0 : DATA_W'(i);
            end
        end else if (wr_ok) begin
            rf[A3] <= merge(rf[A3], WD, WBE);
        end
    end

    // Scoreboard next state. Issue is applied after writeback so that a
    // same-cycle issue and writeback to one register leaves it busy: the
    // write retires the old producer, the new producer is still in flight.
    always_comb begin
        busy_next = busy;
        if (wr_ok)  busy_next[A3]     = 1'b0;
        if (iss_ok) busy_next[iss_rd] = 1'b1;
    end

    always_ff @(posedge Clk_CPU or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Read ports.
    logic zero1, zero2, fwd1, fwd2;

    assign zero1 = (ZERO_REG != 0) && (A1 == '0);
    assign zero2 = (ZERO_REG != 0) && (A2 == '0);
    assign fwd1  = (BYPASS != 0) && wr_live && (A3 == A1);
    assign fwd2  = (BYPASS != 0) && wr_live && (A3 == A2);

    assign RD1 = zero1 ? '0 : (fwd1 ? merge(rf[A1], WD, WBE) : rf[A1]);
    assign RD2 = zero2 ? '0 : (fwd2 ? merge(rf[A2], WD, WBE) : rf[A2]);

    // A forwarded operand is no longer pending: its value is on the bus now.
    assign busy1 = !zero1 && !fwd1 && busy[A1];
    assign busy2 = !zero2 && !fwd2 && busy[A2];

    assign stall = (use1 && busy1) || (use2 && busy2);

endmodule

// File: tb/tb_rf_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_rf_scoreboard
//
// Drives three register-file instances:
//   dut_b  default parameters (BYPASS=1)
//   dut_n  BYPASS=0, sharing every input with dut_b
//   dut_s  DATA_W=16, ADDR_W=3, INIT_MODE=1, own inputs
// A behavioural model (plain arrays of register values and busy flags) is
// stepped at each rising edge and predicts every output of dut_b and dut_n.
// -----------------------------------------------------------------------------
module tb_rf_scoreboard;

    // ---------------------------------------------------------------- clock/reset
    logic Clk_CPU = 1'b0;
    logic rst;
    always #5 Clk_CPU = ~Clk_CPU;

    // ---------------------------------------------------------------- shared inputs
    logic [4:0]  A1, A2, A3, iss_rd;
    logic        use1, use2, RFWr, iss_valid, flush;
    logic [31:0] WD;
    logic [3:0]  WBE;

    logic [31:0] b_RD1, b_RD2, n_RD1, n_RD2;
    logic        b_busy1, b_busy2, b_stall, n_busy1, n_busy2, n_stall;

    // ---------------------------------------------------------------- small instance
    logic [2:0]  s_A1, s_A2, s_A3, s_iss_rd;
    logic        s_use1, s_use2, s_RFWr, s_iss_valid, s_flush;
    logic [15:0] s_WD, s_RD1, s_RD2;
    logic [1:0]  s_WBE;
    logic        s_busy1, s_busy2, s_stall;

    rf_scoreboard dut_b (
        .Clk_CPU(Clk_CPU), .rst(rst), .A1(A1), .A2(A2), .use1(use1), .use2(use2),
        .RD1(b_RD1), .RD2(b_RD2), .RFWr(RFWr), .A3(A3), .WD(WD), .WBE(WBE),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
        .busy1(b_busy1), .busy2(b_busy2), .stall(b_stall)
    );

    rf_scoreboard #(.BYPASS(0)) dut_n (
        .Clk_CPU(Clk_CPU), .rst(rst), .A1(A1), .A2(A2), .use1(use1), .use2(use2),
        .RD1(n_RD1), .RD2(n_RD2), .RFWr(RFWr), .A3(A3), .WD(WD), .WBE(WBE),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
        .busy1(n_busy1), .busy2(n_busy2), .stall(n_stall)
    );

    rf_scoreboard #(.DATA_W(16), .ADDR_W(3), .INIT_MODE(1)) dut_s (
        .Clk_CPU(Clk_CPU), .rst(rst), .A1(s_A1), .A2(s_A2), .use1(s_use1), .use2(s_use2),
        .RD1(s_RD1), .RD2(s_RD2), .RFWr(s_RFWr), .A3(s_A3), .WD(s_WD), .WBE(s_WBE),
        .iss_valid(s_iss_valid), .iss_rd(s_iss_rd), .flush(s_flush),
        .busy1(s_busy1), .busy2(s_busy2), .stall(s_stall)
    );

    // ---------------------------------------------------------------- reference model
    logic [31:0] rf_m [32];
    bit          busy_m [32];
    int          n_asserts = 0;
    int          n_fail    = 0;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            rf_m[i]   = 32'(i);
            busy_m[i] = 1'b0;
        end
    endfunction

    // Value register a would hold after the current write lands.
    function automatic logic [31:0] written(input logic [31:0] old);
        logic [31:0] v;
        v = old;
        for (int k = 0; k < 4; k++)
            if (WBE[k]) v[8*k +: 8] = WD[8*k +: 8];
        return v;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && RFWr && !rst && A3 == a) return written(rf_m[a]);
        return rf_m[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && RFWr && !rst && A3 == a) return 1'b0;
        return busy_m[a];
    endfunction

    // Rising-edge update of the model from the inputs held across the edge.
    function automatic void model_step();
        if (rst) begin
            model_reset();
            return;
        end
        if (RFWr && A3 != 0) rf_m[A3] = written(rf_m[A3]);
        if (flush) begin
            for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
        end else begin
            if (RFWr && A3 != 0) busy_m[A3] = 1'b0;
            if (iss_valid && iss_rd != 0) busy_m[iss_rd] = 1'b1;
        end
    endfunction

    // ---------------------------------------------------------------- scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic eb1, eb2, en1, en2;
        eb1 = exp_busy(A1, 1'b1);
        eb2 = exp_busy(A2, 1'b1);
        en1 = exp_busy(A1, 1'b0);
        en2 = exp_busy(A2, 1'b0);
        check("b_rd1",   b_RD1,   exp_rd(A1, 1'b1));
        check("b_rd2",   b_RD2,   exp_rd(A2, 1'b1));
        check("b_busy1", 32'(b_busy1), 32'(eb1));
        check("b_busy2", 32'(b_busy2), 32'(eb2));
        check("b_stall", 32'(b_stall), 32'((use1 & eb1) | (use2 & eb2)));
        check("n_rd1",   n_RD1,   exp_rd(A1, 1'b0));
        check("n_rd2",   n_RD2,   exp_rd(A2, 1'b0));
        check("n_busy1", 32'(n_busy1), 32'(en1));
        check("n_busy2", 32'(n_busy2), 32'(en2));
        check("n_stall", 32'(n_stall), 32'((use1 & en1) | (use2 & en2)));
    endtask

    // ---------------------------------------------------------------- driver tasks
    task automatic idle();
        RFWr = 1'b0; A3 = '0; WD = '0; WBE = '0;
        iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
    endtask

    // Check outputs mid-cycle, then advance past the next rising edge.
    task automatic cycle();
        @(negedge Clk_CPU);
        check_all();
        @(posedge Clk_CPU);
        model_step();
        #1;
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        rst = 1'b1;
        idle();
        A1 = 5'd5; A2 = 5'd31; use1 = 1'b1; use2 = 1'b1;
        s_A1 = '0; s_A2 = '0; s_A3 = '0; s_iss_rd = '0; s_use1 = 1'b0; s_use2 = 1'b0;
        s_RFWr = 1'b0; s_iss_valid = 1'b0; s_flush = 1'b0; s_WD = '0; s_WBE = '0;
        model_reset();
        #2;
        check_all();
        @(posedge Clk_CPU);
        @(posedge Clk_CPU);
        #1 rst = 1'b0;

        // Reset values after release.
        #1;
        check("rst_rd1_5",  b_RD1, 32'd5);
        check("rst_rd2_31", b_RD2, 32'd31);
        check("rst_stall",  32'(b_stall), 32'd0);
        cycle();
        A1 = 5'd0;
        #1 check("rd_zero", b_RD1, 32'd0);
        cycle();

        // Byte write to reg 7 with same-cycle read.
        RFWr = 1'b1; A3 = 5'd7; WD = 32'hAABBCCDD; WBE = 4'b0101; A1 = 5'd7; A2 = 5'd7;
        #1;
        check("byte_bypass", b_RD1, 32'h00BB00DD);
        check("byte_nobyp",  n_RD1, 32'd7);
        cycle();
        idle();
        #1;
        check("byte_next_b", b_RD1, 32'h00BB00DD);
        check("byte_next_n", n_RD2, 32'h00BB00DD);
        cycle();

        // Zero register ignores write and issue.
        RFWr = 1'b1; A3 = 5'd0; WD = 32'hFFFFFFFF; WBE = 4'hF;
        iss_valid = 1'b1; iss_rd = 5'd0; A1 = 5'd0;
        cycle();
        idle();
        #1;
        check("zero_rd",   b_RD1, 32'd0);
        check("zero_busy", 32'(b_busy1), 32'd0);
        cycle();

        // Scoreboard: issue reg 3, hold, writeback four cycles later.
        iss_valid = 1'b1; iss_rd = 5'd3; A1 = 5'd3; use1 = 1'b1;
        cycle();
        idle();
        #1;
        check("sb_busy",  32'(b_busy1), 32'd1);
        check("sb_stall", 32'(b_stall), 32'd1);
        cycle();
        use1 = 1'b0;
        #1 check("sb_nouse", 32'(b_stall), 32'd0);
        cycle();
        use1 = 1'b1;
        cycle();
        RFWr = 1'b1; A3 = 5'd3; WD = 32'h12345678; WBE = 4'hF;
        #1;
        check("wb_busy_b", 32'(b_busy1), 32'd0);
        check("wb_rd_b",   b_RD1, 32'h12345678);
        check("wb_busy_n", 32'(n_busy1), 32'd1);
        cycle();
        idle();
        #1 check("wb_after_n", 32'(n_busy1), 32'd0);
        cycle();

        // Simultaneous issue and writeback to reg 9.
        iss_valid = 1'b1; iss_rd = 5'd9; RFWr = 1'b1; A3 = 5'd9; WD = 32'hCAFEF00D; WBE = 4'hF;
        cycle();
        idle();
        A1 = 5'd9;
        #1;
        check("same_busy", 32'(b_busy1), 32'd1);
        check("same_rd",   b_RD1, 32'hCAFEF00D);
        cycle();

        // Flush beats a same-cycle issue.
        iss_valid = 1'b1; iss_rd = 5'd5;
        cycle();
        flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd4;
        cycle();
        idle();
        for (int a = 0; a < 32; a++) begin
            A1 = 5'(a);
            #1 check("flush_clear", 32'(b_busy1), 32'd0);
        end
        cycle();

        // Randomised traffic, addresses biased toward a small set for hazards.
        for (int t = 0; t < 400; t++) begin
            A1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            A2 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            A3 = 5'($urandom_range(0, 7));
            iss_rd = 5'($urandom_range(0, 7));
            use1 = 1'($urandom_range(0, 1));
            use2 = 1'($urandom_range(0, 1));
            RFWr = 1'($urandom_range(0, 1));
            iss_valid = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 19) == 0);
            WD = $urandom;
            WBE = 4'($urandom_range(0, 15));
            cycle();
        end

        // Asynchronous reset mid-run: values revert without waiting for a clock.
        idle();
        A1 = 5'd7; A2 = 5'd9;
        rst = 1'b1;
        model_reset();
        #1;
        check("mid_rst_rd1",  b_RD1, 32'd7);
        check("mid_rst_rd2",  n_RD2, 32'd9);
        check("mid_rst_busy", 32'(b_busy2), 32'd0);
        check_all();
        cycle();
        rst = 1'b0;
        for (int t = 0; t < 4; t++) cycle();

        // Narrow instance: 8 x 16 registers, all reset to 0.
        for (int a = 0; a < 8; a++) begin
            s_A1 = 3'(a);
            #1 check("s_reset", 32'(s_RD1), 32'd0);
        end
        s_RFWr = 1'b1; s_A3 = 3'd7; s_WD = 16'hABCD; s_WBE = 2'b10;
        @(posedge Clk_CPU);
        #1;
        s_RFWr = 1'b0; s_A1 = 3'd7;
        #1 check("s_hi_byte", 32'(s_RD1), 32'h0000AB00);
        s_RFWr = 1'b1; s_WD = 16'h1234; s_WBE = 2'b01;
        @(posedge Clk_CPU);
        #1;
        s_RFWr = 1'b0;
        #1 check("s_lo_byte", 32'(s_RD1), 32'h0000AB34);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
